// File: rtl/slave_rx_pkg.sv
// Shared definitions for the serial slave receive port: FSM encoding, parity width, width helper.
// Build option: SLAVE_RX_PARITY_EN appends one even-parity bit to every serial field.
package slave_rx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

`ifdef SLAVE_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_deser.sv
// LSB-first shift-in register for one serial field, with bit counter and optional trailing parity bit.
// o_val/o_perr already include the bit sampled on the current edge, so the FSM can load on that edge.
module serial_deser
  import slave_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_val,
  output logic             o_perr
);

  localparam int NB = WIDTH + PAR_BITS;
  localparam int CW = $clog2(NB + 1);

  logic [WIDTH-1:0] r_sh;
  logic             r_par;
  logic [CW-1:0]    r_cnt;

  logic             w_full;
  logic             w_shift;
  logic             w_pcap;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_par_nxt;

  assign w_full    = (r_cnt == CW'(NB));
  assign w_shift   = i_start | (i_en & (r_cnt < CW'(WIDTH)));
  assign w_pcap    = (PAR_BITS != 0) & i_en & ~i_start & (r_cnt == CW'(WIDTH));
  assign w_base    = i_start ? '0 : r_sh;
  // Shift in at the MSB so the first (LSB) bit ends at bit 0 after WIDTH shifts.
  assign w_sh_nxt  = w_shift ? {i_bit, w_base[WIDTH-1:1]} : r_sh;
  assign w_par_nxt = i_start ? 1'b0 : (w_pcap ? i_bit : r_par);

  assign o_val  = w_sh_nxt;
  assign o_perr = (PAR_BITS != 0) & (^{w_sh_nxt, w_par_nxt});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_par <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sh  <= w_sh_nxt;
      r_par <= w_par_nxt;
      if (i_start)
        r_cnt <= CW'(1);
      else if (i_en && !w_full)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slave_serial_rx.sv
// Serial slave receive port: header/data deserialisation, single and incrementing-burst beats.
// Build option: SLAVE_RX_PARITY_EN (parity bit per field, mismatch flagged on rx_err with rx_done).
module slave_serial_rx
  import slave_rx_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BURST_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              master_valid,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              rx_address,
  input  logic              rx_burst,
  input  logic              rx_data,
  output logic              slave_ready,
  output logic              rx_done,
  output logic              rx_last,
  output logic              rx_is_write,
  output logic              rx_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  localparam int LR = max3(ADDR_W, BURST_W, 0) + PAR_BITS;
  localparam int LW = max3(ADDR_W, BURST_W, DATA_W) + PAR_BITS;
  localparam int DN = DATA_W + PAR_BITS;
  localparam int CW = $clog2(LW + 1);
  localparam logic [CW-1:0] LR_M1 = CW'(LR - 1);
  localparam logic [CW-1:0] LW_M1 = CW'(LW - 1);
  localparam logic [CW-1:0] DN_M1 = CW'(DN - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [BURST_W-1:0] r_blen;
  logic [BURST_W:0]   r_beat;
  logic               r_done, r_last, r_is_write, r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;

  logic               w_hs, w_one_en, w_hdr_start, w_gap_wr, w_dat_start, w_beat_last;
  logic [CW-1:0]      w_hdr_m1;
  logic [ADDR_W-1:0]  w_addr_v;
  logic [BURST_W-1:0] w_burst_v;
  logic [DATA_W-1:0]  w_data_v;
  logic               w_addr_pe, w_burst_pe, w_data_pe;

  assign slave_ready = (r_state == ST_IDLE) | (r_state == ST_GAP);
  assign w_hs        = master_valid & slave_ready;
  assign w_one_en    = read_en ^ write_en;
  assign w_hdr_start = (r_state == ST_IDLE) & w_hs & w_one_en;
  assign w_gap_wr    = (r_state == ST_GAP) & w_hs & write_en & ~read_en;
  assign w_dat_start = w_hdr_start | w_gap_wr;
  assign w_hdr_m1    = r_is_write ? LW_M1 : LR_M1;
  // Beat count after this beat equals burst field + 1.
  assign w_beat_last = (r_beat == {1'b0, r_blen});

  serial_deser #(.WIDTH(ADDR_W)) u_addr (
    .clk(clk), .reset_n(reset_n), .i_start(w_hdr_start), .i_en(r_state == ST_HDR),
    .i_bit(rx_address), .o_val(w_addr_v), .o_perr(w_addr_pe));

  serial_deser #(.WIDTH(BURST_W)) u_burst (
    .clk(clk), .reset_n(reset_n), .i_start(w_hdr_start), .i_en(r_state == ST_HDR),
    .i_bit(rx_burst), .o_val(w_burst_v), .o_perr(w_burst_pe));

  serial_deser #(.WIDTH(DATA_W)) u_data (
    .clk(clk), .reset_n(reset_n), .i_start(w_dat_start),
    .i_en((r_state == ST_HDR) | (r_state == ST_DATA)),
    .i_bit(rx_data), .o_val(w_data_v), .o_perr(w_data_pe));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_blen     <= '0;
      r_beat     <= '0;
      r_done     <= 1'b0;
      r_last     <= 1'b0;
      r_is_write <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs && read_en && write_en) begin
            r_err <= 1'b1;
          end else if (w_hdr_start) begin
            r_is_write <= write_en;
            r_cnt      <= CW'(1);
            r_state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_hdr_m1) begin
            r_addr <= w_addr_v;
            if (r_is_write)
              r_data <= w_data_v;
            r_blen  <= w_burst_v;
            r_beat  <= (BURST_W+1)'(1);
            r_done  <= 1'b1;
            r_last  <= (w_burst_v == '0);
            r_err   <= w_addr_pe | w_burst_pe | (r_is_write & w_data_pe);
            r_state <= (w_burst_v == '0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          // Dropping both enables abandons the rest of the burst silently.
          if (!read_en && !write_en) begin
            r_state <= ST_IDLE;
          end else if (w_hs && read_en && !write_en) begin
            r_addr <= r_addr + 1'b1;
            r_beat <= r_beat + 1'b1;
            r_done <= 1'b1;
            r_last <= w_beat_last;
            if (w_beat_last)
              r_state <= ST_IDLE;
          end else if (w_gap_wr) begin
            r_cnt   <= CW'(1);
            r_state <= ST_DATA;
          end
        end
        default: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == DN_M1) begin
            r_data  <= w_data_v;
            r_addr  <= r_addr + 1'b1;
            r_beat  <= r_beat + 1'b1;
            r_done  <= 1'b1;
            r_last  <= w_beat_last;
            r_err   <= w_data_pe;
            r_state <= w_beat_last ? ST_IDLE : ST_GAP;
          end
        end
      endcase
    end
  end

  assign rx_done     = r_done;
  assign rx_last     = r_last;
  assign rx_is_write = r_is_write;
  assign rx_err      = r_err;
  assign address     = r_addr;
  assign data        = r_data;

endmodule

// File: tb/tb_slave_serial_rx.sv
// Scoreboard bench for slave_serial_rx: directed transfers push expected beats, a monitor pops on rx_done/rx_err.
module tb_slave_serial_rx;

`ifdef SLAVE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        master_valid, read_en, write_en;
  logic        rx_address, rx_burst, rx_data;
  logic        slave_ready, rx_done, rx_last, rx_is_write, rx_err;
  logic [11:0] address;
  logic [7:0]  data;

  slave_serial_rx #(.ADDR_W(12), .DATA_W(8), .BURST_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .master_valid(master_valid),
    .read_en(read_en), .write_en(write_en), .rx_address(rx_address),
    .rx_burst(rx_burst), .rx_data(rx_data), .slave_ready(slave_ready),
    .rx_done(rx_done), .rx_last(rx_last), .rx_is_write(rx_is_write),
    .rx_err(rx_err), .address(address), .data(data));

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        err;
    logic        last;
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  dat;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic done, input logic err, input logic last,
                              input logic wr, input logic [11:0] a, input logic [7:0] d,
                              input int lat);
    exp_t e;
    e.done = done; e.err = err; e.last = last; e.wr = wr;
    e.addr = a; e.dat = d; e.lat = lat;
    return e;
  endfunction

  // Monitor: every rx_done or rx_err must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && (rx_done || rx_err)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got done=%0b err=%0b addr=%0h want no output", rx_done, rx_err, address);
      end else begin
        m_e = q.pop_front();
        chk("rx_done", rx_done, m_e.done);
        chk("rx_err", rx_err, m_e.err);
        if (m_e.done) begin
          chk("rx_last", rx_last, m_e.last);
          chk("rx_is_write", rx_is_write, m_e.wr);
          chk("address", address, m_e.addr);
          chk("data", data, m_e.dat);
          if (m_e.lat >= 0)
            chk("latency", cyc - t_hs, m_e.lat);
        end
      end
    end
  end

  function automatic logic fb(input logic [31:0] v, input int w, input int i, input logic flip);
    logic [31:0] m;
    if (i < w) return v[i];
    m = (32'd1 << w) - 32'd1;
    if (PAR != 0 && i == w) return (^(v & m)) ^ flip;
    return 1'b0;
  endfunction

  task automatic send_hdr(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [7:0] b, input logic [7:0] d, input logic flip_a);
    int len;
    len = 12 + PAR;
    @(negedge clk);
    master_valid = 1'b1; read_en = rd; write_en = wr;
    rx_address = fb(32'(a), 12, 0, flip_a);
    rx_burst   = fb(32'(b), 8, 0, 1'b0);
    rx_data    = fb(32'(d), 8, 0, 1'b0);
    @(posedge clk);
    t_hs = cyc;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      master_valid = 1'b0;
      if (i == 1) chk("ready_in_hdr", slave_ready, 0);
      rx_address = fb(32'(a), 12, i, flip_a);
      rx_burst   = fb(32'(b), 8, i, 1'b0);
      rx_data    = fb(32'(d), 8, i, 1'b0);
      @(posedge clk);
    end
  endtask

  task automatic gap_read();
    @(negedge clk);
    master_valid = 1'b1; read_en = 1'b1; write_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    master_valid = 1'b0;
  endtask

  task automatic gap_write(input logic [7:0] d);
    @(negedge clk);
    master_valid = 1'b1; write_en = 1'b1; read_en = 1'b0;
    rx_data = fb(32'(d), 8, 0, 1'b0);
    @(posedge clk);
    for (int i = 1; i < 8 + PAR; i++) begin
      @(negedge clk);
      master_valid = 1'b0;
      rx_data = fb(32'(d), 8, i, 1'b0);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, slave_ready, 1);
    chk({tag, "_done"}, rx_done, 0);
    chk({tag, "_last"}, rx_last, 0);
    chk({tag, "_iswr"}, rx_is_write, 0);
    chk({tag, "_err"}, rx_err, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_data"}, data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    #12;
    chk_reset_outs("por");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Write single: 0x3A5, burst 0, data 0xC3
    q.push_back(mk(1, 0, 1, 1, 12'h3A5, 8'hC3, 12 + PAR));
    send_hdr(1'b0, 1'b1, 12'h3A5, 8'd0, 8'hC3, 1'b0);
    idle(3);

    // Read burst of 4 beats from 0x010; data holds the last written value
    for (int i = 0; i < 4; i++)
      q.push_back(mk(1, 0, (i == 3), 0, 12'h010 + 12'(i), 8'hC3, -1));
    send_hdr(1'b1, 1'b0, 12'h010, 8'd3, 8'h00, 1'b0);
    repeat (3) gap_read();
    idle(3);

    // Write burst across the address wrap
    q.push_back(mk(1, 0, 0, 1, 12'hFFF, 8'h11, -1));
    q.push_back(mk(1, 0, 1, 1, 12'h000, 8'h22, -1));
    send_hdr(1'b0, 1'b1, 12'hFFF, 8'd1, 8'h11, 1'b0);
    gap_write(8'h22);
    idle(3);

    // Abort a 6-beat read after beat 2
    q.push_back(mk(1, 0, 0, 0, 12'h100, 8'h22, -1));
    q.push_back(mk(1, 0, 0, 0, 12'h101, 8'h22, -1));
    send_hdr(1'b1, 1'b0, 12'h100, 8'd5, 8'h00, 1'b0);
    gap_read();
    @(negedge clk);
    master_valid = 1'b1; read_en = 1'b0; write_en = 1'b0;
    @(posedge clk);
    idle(10);
    chk("ready_after_abort", slave_ready, 1);
    chk("addr_after_abort", address, 12'h101);

    // Asynchronous reset in the middle of a header
    @(negedge clk);
    master_valid = 1'b1; write_en = 1'b1; read_en = 1'b0;
    rx_address = 1'b1; rx_burst = 1'b0; rx_data = 1'b1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      master_valid = 1'b0;
      rx_address = ~rx_address;
      @(posedge clk);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    q.push_back(mk(1, 0, 1, 1, 12'h2B4, 8'h5A, 12 + PAR));
    send_hdr(1'b0, 1'b1, 12'h2B4, 8'd0, 8'h5A, 1'b0);
    idle(3);

    // Both enables with a handshake: error pulse only, stays in IDLE
    q.push_back(mk(0, 1, 0, 0, 12'h000, 8'h00, -1));
    @(negedge clk);
    master_valid = 1'b1; read_en = 1'b1; write_en = 1'b1;
    @(posedge clk);
    idle(2);
    chk("ready_after_err", slave_ready, 1);

    // Read single after the error
    q.push_back(mk(1, 0, 1, 0, 12'h7FE, 8'h5A, -1));
    send_hdr(1'b1, 1'b0, 12'h7FE, 8'd0, 8'h00, 1'b0);
    idle(3);

`ifdef SLAVE_RX_PARITY_EN
    // Corrupted address parity: beat still delivered with rx_err
    q.push_back(mk(1, 1, 1, 1, 12'h0F0, 8'h81, -1));
    send_hdr(1'b0, 1'b1, 12'h0F0, 8'd0, 8'h81, 1'b1);
    idle(3);
`endif

    idle(5);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
